// File: rtl/uart_rx_param_if.sv
// Receive-side handshake bundle: word, error flags and valid/ready toward the CPU I/O port.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] o_Rx_Data;
  logic                 o_Rx_Valid;
  logic                 i_Rx_Ready;
  logic                 o_Parity_Err;
  logic                 o_Frame_Err;
  logic                 o_Overrun;

  modport master (
    output o_Rx_Data, o_Rx_Valid, o_Parity_Err, o_Frame_Err, o_Overrun,
    input  i_Rx_Ready
  );

  modport slave (
    input  o_Rx_Data, o_Rx_Valid, o_Parity_Err, o_Frame_Err, o_Overrun,
    output i_Rx_Ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with parity/framing/overrun reporting and a held output word.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting around each sample point.
module uart_rx_param #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  input  logic            i_Rx_Serial,
  output logic            o_Busy,
  uart_rx_param_if.master rx_if
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] MidCnt  = CntW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);
  localparam logic            LastStop = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StDone, StBreak} state_e;

  state_e                 state_q, state_d;
  logic                   sync1_q, sync2_q, samp;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d, pe_q, pe_d, fe_q, fe_d, ovr_q, ovr_d;
  logic                   done;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_Rx_Serial;
      sync2_q <= sync1_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // sync1_q already holds the next cycle's bit, so the vote spans mid-1..mid+1 without delay.
  logic prev_q;
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) prev_q <= 1'b1;
    else         prev_q <= sync2_q;
  end
  assign samp = (prev_q & sync2_q) | (prev_q & sync1_q) | (sync2_q & sync1_q);
`else
  assign samp = sync2_q;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!sync2_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == MidCnt) begin
          cnt_d = '0;
          if (!samp) begin
            state_d    = StData;
            idx_d      = '0;
            stop_idx_d = 1'b0;
            par_err_d  = 1'b0;
            frm_err_d  = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          shift_d = {samp, shift_q[DATA_BITS-1:1]};
          if (idx_q == LastIdx) state_d = (PARITY_MODE != 0) ? StParity : StStop;
          else                  idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StParity: begin
        if (cnt_q == LastCnt) begin
          cnt_d     = '0;
          par_err_d = (PARITY_MODE == 1) ? (^{shift_q, samp}) : ~(^{shift_q, samp});
          state_d   = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == LastCnt) begin
          cnt_d = '0;
          if (!samp) frm_err_d = 1'b1;
          if (stop_idx_q == LastStop) state_d    = StDone;
          else                        stop_idx_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = frm_err_q ? StBreak : StIdle;
      end
      StBreak: begin
        if (sync2_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    ovr_d   = 1'b0;
    if (valid_q && rx_if.i_Rx_Ready) valid_d = 1'b0;
    if (done) begin
      if (!valid_q || rx_if.i_Rx_Ready) begin
        valid_d = 1'b1;
        data_d  = shift_q;
        pe_d    = par_err_q;
        fe_d    = frm_err_q;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_if.o_Rx_Data    = data_q;
  assign rx_if.o_Rx_Valid   = valid_q;
  assign rx_if.o_Parity_Err = pe_q;
  assign rx_if.o_Frame_Err  = fe_q;
  assign rx_if.o_Overrun    = ovr_q;
  assign o_Busy             = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 7E1, 9O2) driven from a frame-level model.
module tb_uart_rx_param;
  localparam int CPB = 16;
  localparam int DBITS [3] = '{8, 7, 9};
  localparam int PMODE [3] = '{0, 1, 2};
  localparam int SBITS [3] = '{1, 1, 2};

  typedef struct packed {
    logic [1:0] dut;
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } word_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] ser = 3'b111;
  logic [2:0] rdy = 3'b111;
  logic [2:0] busy, vld, pe, fe, ovr;
  logic [8:0] dat [3];
  int         total = 0;
  int         bad = 0;
  int         vcyc [3] = '{0, 0, 0};
  int         ocnt [3] = '{0, 0, 0};
  word_t      got_q [$];

  always #5 clk = ~clk;

  uart_rx_param_if #(.DATA_BITS(8)) if0 ();
  uart_rx_param_if #(.DATA_BITS(7)) if1 ();
  uart_rx_param_if #(.DATA_BITS(9)) if2 ();

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_dut0 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(ser[0]), .o_Busy(busy[0]), .rx_if(if0)
  );
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1)) u_dut1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(ser[1]), .o_Busy(busy[1]), .rx_if(if1)
  );
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY_MODE(2), .STOP_BITS(2)) u_dut2 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(ser[2]), .o_Busy(busy[2]), .rx_if(if2)
  );

  assign if0.i_Rx_Ready = rdy[0];
  assign if1.i_Rx_Ready = rdy[1];
  assign if2.i_Rx_Ready = rdy[2];
  assign dat[0] = {1'b0, if0.o_Rx_Data};
  assign dat[1] = {2'b0, if1.o_Rx_Data};
  assign dat[2] = if2.o_Rx_Data;
  assign vld = {if2.o_Rx_Valid, if1.o_Rx_Valid, if0.o_Rx_Valid};
  assign pe  = {if2.o_Parity_Err, if1.o_Parity_Err, if0.o_Parity_Err};
  assign fe  = {if2.o_Frame_Err, if1.o_Frame_Err, if0.o_Frame_Err};
  assign ovr = {if2.o_Overrun, if1.o_Overrun, if0.o_Overrun};

  // Inputs change just after posedge, so the negedge view is what the next edge will act on.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i]) vcyc[i] <= vcyc[i] + 1;
      if (ovr[i]) ocnt[i] <= ocnt[i] + 1;
      if (vld[i] && rdy[i]) got_q.push_back({2'(i), dat[i], pe[i], fe[i]});
    end
  end

  function automatic int flen(int d);
    return 1 + DBITS[d] + ((PMODE[d] != 0) ? 1 : 0) + SBITS[d];
  endfunction

  // Line image of one frame, bit 0 = start bit.
  function automatic logic [15:0] frame(int d, logic [8:0] data, bit pflip, bit lstop);
    logic [15:0] f;
    logic [8:0]  m;
    int          n;
    f = '1;
    m = data & 9'((1 << DBITS[d]) - 1);
    f[0] = 1'b0;
    for (int i = 0; i < DBITS[d]; i++) f[1 + i] = m[i];
    n = 1 + DBITS[d];
    if (PMODE[d] != 0) begin
      f[n] = ((PMODE[d] == 1) ? (^m) : ~(^m)) ^ pflip;
      n++;
    end
    f[n + SBITS[d] - 1] = lstop;
    return f;
  endfunction

  function automatic word_t model(int d, logic [8:0] data, bit pflip, bit lstop);
    word_t w;
    w.dut  = 2'(d);
    w.data = data & 9'((1 << DBITS[d]) - 1);
    w.pe   = (PMODE[d] != 0) && pflip;
    w.fe   = !lstop;
    return w;
  endfunction

  function automatic word_t get(int i);
    if (i < got_q.size()) return got_q[i];
    return '1;
  endfunction

  task automatic drive(int d, logic [15:0] f, int c0, int c1, int gpos);
    for (int k = c0; k < c1; k++) begin
      @(posedge clk);
      #1;
      ser[d] = f[k / CPB] ^ ((k / CPB == gpos) && (k % CPB == CPB / 2));
    end
  endtask

  task automatic send(int d, logic [8:0] data, bit pflip, bit lstop, int gpos);
    drive(d, frame(d, data, pflip, lstop), 0, flen(d) * CPB, gpos);
  endtask

  task automatic line(int d, logic v, int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ser[d] = v;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++; if (vld !== 3'b000) begin bad++; $display("FAIL reset_valid got=%b want=000", vld); end
    total++; if (busy !== 3'b000) begin bad++; $display("FAIL reset_busy got=%b want=000", busy); end
    total++;
    if ({pe, fe, ovr} !== 9'd0) begin
      bad++; $display("FAIL reset_flags got=%b want=0", {pe, fe, ovr});
    end
    total++;
    if ({dat[0], dat[1], dat[2]} !== 27'd0) begin
      bad++; $display("FAIL reset_data got=%h want=0", {dat[0], dat[1], dat[2]});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
  endtask

  task automatic test_basic;
    int base = got_q.size();
    int v0 = vcyc[0];
    int o0 = ocnt[0];
    word_t exp = model(0, 9'h0A5, 1'b0, 1'b1);
    send(0, 9'h0A5, 1'b0, 1'b1, -1);
    line(0, 1'b1, 32);
    total++;
    if (got_q.size() != base + 1) begin
      bad++; $display("FAIL basic_count got=%0d want=1", got_q.size() - base);
    end
    total++; if (get(base) !== exp) begin bad++; $display("FAIL basic_word got=%h want=%h", get(base), exp); end
    total++;
    if (vcyc[0] - v0 != 1) begin bad++; $display("FAIL basic_valid_cycles got=%0d want=1", vcyc[0] - v0); end
    total++; if (ocnt[0] != o0) begin bad++; $display("FAIL basic_overrun got=%0d want=0", ocnt[0] - o0); end
  endtask

  task automatic test_parity;
    for (int f = 0; f < 2; f++) begin
      int base = got_q.size();
      word_t exp = model(1, 9'h041, f[0], 1'b1);
      send(1, 9'h041, f[0], 1'b1, -1);
      line(1, 1'b1, 32);
      total++;
      if (get(base) !== exp) begin
        bad++; $display("FAIL parity_word flip=%0d got=%h want=%h", f, get(base), exp);
      end
    end
  endtask

  task automatic test_break;
    int base = got_q.size();
    word_t exp = model(2, 9'h03C, 1'b0, 1'b0);
    send(2, 9'h03C, 1'b0, 1'b0, -1);
    line(2, 1'b0, 40 * CPB);
    total++;
    if (got_q.size() != base + 1 || get(base) !== exp) begin
      bad++; $display("FAIL break_word n=%0d got=%h want=%h", got_q.size() - base, get(base), exp);
    end
    total++; if (busy[2] !== 1'b1) begin bad++; $display("FAIL break_busy got=%b want=1", busy[2]); end
    line(2, 1'b1, 64);
    total++; if (busy[2] !== 1'b0) begin bad++; $display("FAIL break_exit got=%b want=0", busy[2]); end
    total++;
    if (got_q.size() != base + 1) begin
      bad++; $display("FAIL break_extra got=%0d want=1", got_q.size() - base);
    end
    exp = model(2, 9'h155, 1'b0, 1'b1);
    send(2, 9'h155, 1'b0, 1'b1, -1);
    line(2, 1'b1, 48);
    total++; if (get(base + 1) !== exp) begin bad++; $display("FAIL break_next got=%h want=%h", get(base + 1), exp); end
  endtask

  task automatic test_overrun;
    int base = got_q.size();
    int o0 = ocnt[0];
    rdy[0] = 1'b0;
    send(0, 9'h011, 1'b0, 1'b1, -1);
    line(0, 1'b1, 16);
    send(0, 9'h022, 1'b0, 1'b1, -1);
    line(0, 1'b1, 32);
    total++; if (dat[0] !== 9'h011) begin bad++; $display("FAIL ovr_held got=%h want=011", dat[0]); end
    total++; if (vld[0] !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b want=1", vld[0]); end
    total++; if (ocnt[0] - o0 != 1) begin bad++; $display("FAIL ovr_pulses got=%0d want=1", ocnt[0] - o0); end
    rdy[0] = 1'b1;
    @(posedge clk);
    #1;
    total++; if (vld[0] !== 1'b0) begin bad++; $display("FAIL ovr_drain_valid got=%b want=0", vld[0]); end
    total++;
    if (got_q.size() != base + 1 || get(base).data !== 9'h011) begin
      bad++; $display("FAIL ovr_drain_word n=%0d got=%h want=011", got_q.size() - base, get(base).data);
    end
  endtask

  task automatic test_short_pulse;
    int base = got_q.size();
    line(0, 1'b0, 5);
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL pulse_busy got=%b want=1", busy[0]); end
    line(0, 1'b1, 48);
    total++;
    if (got_q.size() != base || vld[0] !== 1'b0 || busy[0] !== 1'b0) begin
      bad++; $display("FAIL pulse_idle n=%0d valid=%b busy=%b want 0/0/0", got_q.size() - base, vld[0], busy[0]);
    end
  endtask

  task automatic test_reset_mid;
    int base = got_q.size();
    logic [15:0] f = frame(0, 9'h0F0, 1'b0, 1'b1);
    rdy[0] = 1'b0;
    send(0, 9'h077, 1'b0, 1'b1, -1);
    line(0, 1'b1, 32);
    total++; if (dat[0] !== 9'h077) begin bad++; $display("FAIL rstmid_held got=%h want=077", dat[0]); end
    drive(0, f, 0, 3 * CPB + 4, -1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if (vld[0] !== 1'b0 || dat[0] !== 9'h0 || busy[0] !== 1'b0) begin
      bad++; $display("FAIL rstmid_async valid=%b data=%h busy=%b want 0/0/0", vld[0], dat[0], busy[0]);
    end
    drive(0, f, 3 * CPB + 4, 5 * CPB + 4, -1);
    rst = 1'b0;
    drive(0, f, 5 * CPB + 4, flen(0) * CPB, -1);
    rdy[0] = 1'b1;
    line(0, 1'b1, 48);
    total++;
    if (got_q.size() != base || vld[0] !== 1'b0) begin
      bad++; $display("FAIL rstmid_noword n=%0d valid=%b want 0/0", got_q.size() - base, vld[0]);
    end
  endtask

  task automatic test_majority;
    int base = got_q.size();
    word_t exp;
`ifdef UART_RX_MAJORITY_EN
    exp = model(0, 9'h05A, 1'b0, 1'b1);
`else
    exp = model(0, 9'h05A ^ 9'h008, 1'b0, 1'b1);
`endif
    send(0, 9'h05A, 1'b0, 1'b1, 4);
    line(0, 1'b1, 32);
    total++; if (get(base) !== exp) begin bad++; $display("FAIL glitch_word got=%h want=%h", get(base), exp); end
  endtask

  task automatic test_back_to_back;
    int base = got_q.size();
    int o0 = ocnt[0];
    logic [8:0] d [5];
    for (int i = 0; i < 5; i++) begin
      d[i] = 9'($urandom);
      send(0, d[i], 1'b0, 1'b1, -1);
    end
    line(0, 1'b1, 32);
    total++;
    if (got_q.size() != base + 5) begin
      bad++; $display("FAIL b2b_count got=%0d want=5", got_q.size() - base);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (get(base + i) !== model(0, d[i], 1'b0, 1'b1)) begin
        bad++; $display("FAIL b2b_word%0d got=%h want=%h", i, get(base + i), model(0, d[i], 1'b0, 1'b1));
      end
    end
    total++; if (ocnt[0] != o0) begin bad++; $display("FAIL b2b_overrun got=%0d want=0", ocnt[0] - o0); end
  endtask

  task automatic test_random;
    for (int it = 0; it < 12; it++) begin
      int base = got_q.size();
      int d = int'($urandom_range(0, 2));
      logic [8:0] data = 9'($urandom);
      bit pf = (PMODE[d] != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      bit ls = ($urandom_range(0, 3) != 0);
      word_t exp = model(d, data, pf, ls);
      send(d, data, pf, ls, -1);
      line(d, 1'b1, 48);
      total++;
      if (got_q.size() != base + 1 || get(base) !== exp) begin
        bad++;
        $display("FAIL rand%0d dut=%0d n=%0d got=%h want=%h", it, d, got_q.size() - base, get(base), exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_overrun();
    test_short_pulse();
    test_reset_mid();
    test_majority();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
